// File: rtl/multi_edge_counter_pkg.sv
// multi_edge_counter_pkg
//   Shared types and constants for the multi-channel edge counter.
//   edge_mode_t : edge select encoding driven on edge_mode_i
//   GUARD_W     : width of the post-reset arm guard counter. It holds values
//                 up to SYNC_STAGES+1, so SYNC_STAGES is limited to 30.
package multi_edge_counter_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_t;

    localparam int unsigned GUARD_W = 5;

endpackage

// File: rtl/edge_counter_chan.sv
// edge_counter_chan
//   One counter channel. It contains the synchronizer for next_i, the delay
//   flop used for edge detection, and the count and tc registers.
//   Ports:
//     clk_i, rstn_i   clock, async active-high reset
//     next_i          raw (possibly asynchronous) event input
//     armed_i         edge detection enable from the shared arm guard
//     edge_mode_i     edge select (edge_mode_t encoding)
//     sat_i, dir_i    saturate/wrap select, up/down select
//     clr_i, load_i   synchronous clear and load (clear has priority)
//     load_val_i      load value
//     limit_i         upper bound for the count
//     count_o, tc_o   registered count and one-cycle terminal-count pulse
module edge_counter_chan
    import multi_edge_counter_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   next_i,
    input  logic                   armed_i,
    input  logic [1:0]             edge_mode_i,
    input  logic                   sat_i,
    input  logic                   dir_i,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic [COUNT_WIDTH-1:0] load_val_i,
    input  logic [COUNT_WIDTH-1:0] limit_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   tc_o
);

    logic                   sync_s;
    logic                   dly_q;
    logic                   hit;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   tc_q, tc_d;

    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge clk_i or posedge rstn_i) begin
            if (rstn_i) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= next_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign sync_s = sync_q[SYNC_STAGES-1];
    end else begin : g_bypass
        // Input is already synchronous to clk_i.
        assign sync_s = next_i;
    end

    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) dly_q <= 1'b0;
        else        dly_q <= sync_s;
    end

    always_comb begin
        hit = 1'b0;
        case (edge_mode_t'(edge_mode_i))
            EDGE_RISE: hit = sync_s & ~dly_q;
            EDGE_FALL: hit = ~sync_s & dly_q;
            EDGE_BOTH: hit = sync_s ^ dly_q;
            EDGE_OFF:  hit = 1'b0;
            default:   hit = 1'b0;
        endcase
        // Masked during the guard so a level held at reset release is not counted.
        hit = hit & armed_i;
    end

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (hit) begin
            if (dir_i) begin
                // Uses >= so a loaded value above limit_i still terminates.
                if (cnt_q >= limit_i) begin
                    tc_d = 1'b1;
                    if (!sat_i) cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    tc_d = 1'b1;
                    if (!sat_i) cnt_d = limit_i;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign count_o = cnt_q;
    assign tc_o    = tc_q;

endmodule

// File: rtl/multi_edge_counter.sv
// multi_edge_counter
//   N_CHAN independent edge counters with a shared arm guard. Each channel
//   counts selected edges of its next_i bit, which may be asynchronous.
//   Ports:
//     clk_i, rstn_i   clock, async active-high reset
//     next_i          per-channel event inputs
//     edge_mode_i     global edge select: rise/fall/both/off
//     sat_i           1 saturate, 0 wrap
//     dir_i           per-channel direction, 1 = up
//     clr_i, load_i   per-channel synchronous clear and load
//     load_val_i      packed load values, channel c at [c*COUNT_WIDTH +: COUNT_WIDTH]
//     limit_i         shared upper bound
//     count_o, tc_o   packed counts (same packing) and terminal-count pulses
module multi_edge_counter
    import multi_edge_counter_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int N_CHAN      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [N_CHAN-1:0]             next_i,
    input  logic [1:0]                    edge_mode_i,
    input  logic                          sat_i,
    input  logic [N_CHAN-1:0]             dir_i,
    input  logic [N_CHAN-1:0]             clr_i,
    input  logic [N_CHAN-1:0]             load_i,
    input  logic [N_CHAN*COUNT_WIDTH-1:0] load_val_i,
    input  logic [COUNT_WIDTH-1:0]        limit_i,
    output logic [N_CHAN*COUNT_WIDTH-1:0] count_o,
    output logic [N_CHAN-1:0]             tc_o
);

    localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(SYNC_STAGES + 1);

    logic [GUARD_W-1:0]                   guard_q;
    logic                                 armed;
    logic [N_CHAN-1:0][COUNT_WIDTH-1:0]   ld_val;
    logic [N_CHAN-1:0][COUNT_WIDTH-1:0]   cnt;

    // Guard counts down while the synchronizer and delay flop fill with
    // post-reset samples. Edges are detected only after it reaches zero.
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i)               guard_q <= GUARD_INIT;
        else if (guard_q != '0)   guard_q <= guard_q - 1'b1;
    end

    assign armed   = (guard_q == '0);
    assign ld_val  = load_val_i;
    assign count_o = cnt;

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        edge_counter_chan #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .next_i      (next_i[c]),
            .armed_i     (armed),
            .edge_mode_i (edge_mode_i),
            .sat_i       (sat_i),
            .dir_i       (dir_i[c]),
            .clr_i       (clr_i[c]),
            .load_i      (load_i[c]),
            .load_val_i  (ld_val[c]),
            .limit_i     (limit_i),
            .count_o     (cnt[c]),
            .tc_o        (tc_o[c])
        );
    end

endmodule

// File: tb/tb_multi_edge_counter.sv
// tb_multi_edge_counter
//   Scoreboard bench: expected count/tc are queued when next_i is driven and
//   compared once the synchronizer latency has elapsed.
module tb_multi_edge_counter;

    localparam int CW  = 8;
    localparam int NC  = 4;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic [NC-1:0]     next_i;
    logic [1:0]        edge_mode_i;
    logic              sat_i;
    logic [NC-1:0]     dir_i;
    logic [NC-1:0]     clr_i;
    logic [NC-1:0]     load_i;
    logic [NC*CW-1:0]  load_val_i;
    logic [CW-1:0]     limit_i;
    logic [NC*CW-1:0]  count_o;
    logic [NC-1:0]     tc_o;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string         tag;
        int            chan;
        logic [CW-1:0] cnt;
        logic          tc;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    multi_edge_counter #(
        .COUNT_WIDTH (CW),
        .N_CHAN      (NC),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .next_i      (next_i),
        .edge_mode_i (edge_mode_i),
        .sat_i       (sat_i),
        .dir_i       (dir_i),
        .clr_i       (clr_i),
        .load_i      (load_i),
        .load_val_i  (load_val_i),
        .limit_i     (limit_i),
        .count_o     (count_o),
        .tc_o        (tc_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int c);
        return count_o[c*CW +: CW];
    endfunction

    task automatic sb_push(input string tag, input int c, input logic [CW-1:0] cnt, input logic tc);
        exp_t e;
        e.tag  = tag;
        e.chan = c;
        e.cnt  = cnt;
        e.tc   = tc;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_cnt"}, 32'(cnt_of(e.chan)), 32'(e.cnt));
            chk({e.tag, "_tc"}, 32'(tc_o[e.chan]), 32'(e.tc));
        end
    endtask

    // Flip next_i[c]; the result appears LAT edges after the first sampling edge.
    task automatic toggle(input int c, input logic [CW-1:0] ecnt, input logic etc, input string tag);
        sb_push(tag, c, ecnt, etc);
        next_i[c] = ~next_i[c];
        repeat (LAT) tick();
        sb_pop();
    endtask

    // Rise then fall; in rising mode the fall must not count and tc must drop.
    task automatic pulse(input int c, input logic [CW-1:0] ecnt, input logic etc, input string tag);
        toggle(c, ecnt, etc, tag);
        tick();
        chk({tag, "_tc1cyc"}, 32'(tc_o[c]), 32'd0);
        toggle(c, ecnt, 1'b0, {tag, "_fall"});
    endtask

    int seq_cnt[7] = '{1, 2, 3, 4, 5, 0, 1};
    int seq_tc[7]  = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        rstn_i      = 1'b1;
        next_i      = '1;
        edge_mode_i = 2'b00;
        sat_i       = 1'b0;
        dir_i       = '1;
        clr_i       = '0;
        load_i      = '0;
        load_val_i  = '0;
        limit_i     = 8'd5;

        repeat (2) tick();
        chk("rst_cnt", count_o, 32'd0);
        chk("rst_tc", 32'(tc_o), 32'd0);

        // Release with next_i high: the held level must never count.
        rstn_i = 1'b0;
        repeat (6) tick();
        chk("guard_cnt", count_o, 32'd0);
        chk("guard_tc", 32'(tc_o), 32'd0);
        next_i = '0;
        repeat (LAT) tick();
        chk("fall_ignored", count_o, 32'd0);
        pulse(3, 8'd1, 1'b0, "post_guard");
        clr_i[3] = 1'b1;
        tick();
        clr_i = '0;
        chk("clr3", 32'(cnt_of(3)), 32'd0);

        // Rising, up, wrap at limit 5.
        for (int i = 0; i < 7; i++) begin
            pulse(0, CW'(seq_cnt[i]), seq_tc[i][0], $sformatf("wrap_up%0d", i));
        end
        chk("others_idle", 32'(count_o[NC*CW-1:CW]), 32'd0);

        // Latency: change lands on the third edge after first sampling.
        next_i[1] = 1'b1;
        tick();
        tick();
        chk("lat_e2", 32'(cnt_of(1)), 32'd0);
        tick();
        chk("lat_e3", 32'(cnt_of(1)), 32'd1);
        next_i[1] = 1'b0;
        repeat (LAT) tick();

        // Both edges, down, saturate from a load of 2.
        load_val_i[1*CW +: CW] = 8'd2;
        load_i[1] = 1'b1;
        tick();
        load_i = '0;
        chk("load2", 32'(cnt_of(1)), 32'd2);
        edge_mode_i = 2'b10;
        dir_i[1]    = 1'b0;
        sat_i       = 1'b1;
        toggle(1, 8'd1, 1'b0, "both_dn1");
        toggle(1, 8'd0, 1'b0, "both_dn2");
        toggle(1, 8'd0, 1'b1, "both_sat");
        tick();
        chk("both_tc1cyc", 32'(tc_o[1]), 32'd0);
        edge_mode_i = 2'b00;
        sat_i       = 1'b0;
        dir_i       = '1;
        toggle(1, 8'd0, 1'b0, "rise_mode_fall");

        // clr/load coincident with a detected edge on channel 2.
        load_val_i[2*CW +: CW] = 8'd9;
        next_i[2] = 1'b1;
        tick();
        tick();
        clr_i[2]  = 1'b1;
        load_i[2] = 1'b1;
        tick();
        clr_i  = '0;
        load_i = '0;
        chk("clr_pri_cnt", 32'(cnt_of(2)), 32'd0);
        chk("clr_pri_tc", 32'(tc_o[2]), 32'd0);
        repeat (LAT) tick();
        chk("clr_drop", 32'(cnt_of(2)), 32'd0);
        next_i[2] = 1'b0;
        repeat (LAT) tick();
        next_i[2] = 1'b1;
        tick();
        tick();
        load_i[2] = 1'b1;
        tick();
        load_i = '0;
        chk("load_pri_cnt", 32'(cnt_of(2)), 32'd9);
        chk("load_pri_tc", 32'(tc_o[2]), 32'd0);
        repeat (LAT) tick();
        chk("load_drop", 32'(cnt_of(2)), 32'd9);
        next_i[2] = 1'b0;
        repeat (LAT) tick();

        // Bounds: saturate at limit, loaded value above limit, limit 0.
        load_val_i[0 +: CW] = 8'd5;
        load_i[0] = 1'b1;
        tick();
        load_i = '0;
        sat_i  = 1'b1;
        pulse(0, 8'd5, 1'b1, "sat_up");
        sat_i  = 1'b0;
        pulse(2, 8'd0, 1'b1, "above_lim");
        limit_i = 8'd0;
        pulse(3, 8'd0, 1'b1, "lim0_a");
        pulse(3, 8'd0, 1'b1, "lim0_b");
        limit_i = 8'd5;

        // Counting disabled, then falling-edge mode.
        edge_mode_i = 2'b11;
        pulse(3, 8'd0, 1'b0, "edge_off");
        edge_mode_i = 2'b01;
        toggle(3, 8'd0, 1'b0, "fall_rise_ign");
        toggle(3, 8'd1, 1'b0, "fall_cnt");
        edge_mode_i = 2'b00;

        // Mid-run asynchronous reset with counts 3/7 and an edge in flight.
        load_val_i[0 +: CW]    = 8'd3;
        load_val_i[1*CW +: CW] = 8'd7;
        load_i = 4'b0011;
        tick();
        load_i = '0;
        chk("pre_rst_c0", 32'(cnt_of(0)), 32'd3);
        chk("pre_rst_c1", 32'(cnt_of(1)), 32'd7);
        next_i[0] = 1'b1;
        tick();
        #2;
        rstn_i = 1'b1;
        #1;
        chk("amid_cnt", count_o, 32'd0);
        chk("amid_tc", 32'(tc_o), 32'd0);
        tick();
        tick();
        rstn_i = 1'b0;
        repeat (LAT + 2) tick();
        chk("inflight_drop", count_o, 32'd0);
        next_i[0] = 1'b0;
        repeat (LAT) tick();
        pulse(0, 8'd1, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/multi_edge_counter.md
# multi_edge_counter

Parametrised multi-channel edge counter: N_CHAN independent counters, each advanced by a selectable edge of an asynchronous event input, after a configurable synchronizer. Each channel supports up/down direction, synchronous clear and load, and a programmable limit with wrap or saturate behaviour and a terminal-count pulse. It replaces the single-channel rising-edge counter in status and event-tally paths.

## Interface
- COUNT_WIDTH, 8: bit width of each channel counter (≥2)
- N_CHAN, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchronizer flops per next_i bit (0 = bypass, event input already synchronous)
- clk_i  input  1  clock, all state on rising edge
- rstn_i  input  1  reset, asynchronous, active-high (state cleared while rstn_i = 1)
- next_i  input  N_CHAN  event inputs, one per channel, may be asynchronous
- edge_mode_i  input  2  global edge select: 00 rising, 01 falling, 10 both, 11 counting disabled
- sat_i  input  1  1 = saturate at bounds, 0 = wrap
- dir_i  input  N_CHAN  per channel: 1 = count up, 0 = count down
- clr_i  input  N_CHAN  per channel synchronous clear to 0
- load_i  input  N_CHAN  per channel synchronous load of load_val_i slice
- load_val_i  input  N_CHAN*COUNT_WIDTH  load values, channel c at [c*COUNT_WIDTH +: COUNT_WIDTH]
- limit_i  input  COUNT_WIDTH  shared upper bound for all channels
- count_o  output  N_CHAN*COUNT_WIDTH  registered counts, same packing as load_val_i
- tc_o  output  N_CHAN  registered one-cycle terminal-count pulse per channel

## Operation
- Per channel: next_i → synchronizer → delay flop; edge = rise (sync & ~dly), fall (~sync & dly), or either, per edge_mode_i.
- Per-channel priority each cycle: clr_i > load_i > counted edge > hold.
- clr_i: count ← 0, tc_o ← 0. load_i: count ← load_val_i slice (may exceed limit_i), tc_o ← 0.
- Counted edge, up: if count ≥ limit_i → wrap: 0; saturate: hold; tc_o ← 1. Else count + 1, tc_o ← 0.
- Counted edge, down: if count = 0 → wrap: limit_i; saturate: hold at 0; tc_o ← 1. Else count − 1, tc_o ← 0.
- No counted edge: count holds, tc_o ← 0.
- Arithmetic unsigned, modulo 2^COUNT_WIDTH never reached (bounded by limit_i or 0). limit_i = 0: up in wrap mode stays 0 and pulses tc_o on every edge.
- edge_mode_i, sat_i, dir_i, limit_i sampled in the cycle the edge is detected; changing them mid-run has no other effect.
- Arm guard: after rstn_i deasserts, edge detection is disabled for SYNC_STAGES+1 cycles while the synchronizer and delay flop fill; a level present on next_i at reset release is never counted. clr_i/load_i act during the guard.

## Timing
- Reset values: count_o all 0, tc_o all 0, synchronizer and delay flops 0, guard reloaded.
- Latency: count_o and tc_o update on clock edge SYNC_STAGES+1 after the edge that first samples a new next_i level (edge 3 for SYNC_STAGES=2; edge 1 for SYNC_STAGES=0).
- clr_i/load_i: effect visible on count_o one edge after sampling.
- next_i levels must be held ≥ SYNC_STAGES+1 cycles to be counted; shorter pulses may be lost.
- Reset mid-count: immediate clear of all outputs, in-flight edges discarded, guard restarts.
- Simultaneous clr_i/load_i and edge: edge dropped, no tc_o.

## Structure
- Package multi_edge_counter_pkg: edge_mode_t enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF), guard counter width constant.
- Sub-module edge_counter_chan: one channel (synchronizer, delay flop, count/tc registers); top instantiates N_CHAN copies via generate and holds the shared arm guard.

## Test plan
- Defaults, limit_i=5, rising, up, wrap: 7 pulses on next_i[0] → count 1,2,3,4,5,0,1; tc_o[0] single pulse on 5→0; other channels stay 0.
- Both-edge, down, saturate, load 2: 3 toggles → 1,0,0; tc_o pulses on the third edge only.
- Latency: SYNC_STAGES=2, next_i[1] rises → count_o[1] changes exactly 3 edges after first sampling edge.
- Reset released with next_i=all 1, rising mode → all counts remain 0 after guard; next real rising edge gives 1.
- clr_i[2] and load_i[2] (val 9) in same cycle as edge → count 0; load alone with edge → 9, no increment.
- Assert rstn_i mid-run with counts 3/7 → all count_o and tc_o 0 immediately, asynchronously.
